// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell plus a carry flop, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed overflow output.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             overflow,
`endif
    output logic             carry
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s_bit;
    logic             c_next;
    logic             last_bit;

    assign s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign c_next   = (a_sh_q[0] & b_sh_q[0]) | (c_q & (a_sh_q[0] ^ b_sh_q[0]));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        if (state_q == IDLE && in_valid) begin
            a_sh_d   = a;
            b_sh_d   = b;
            sum_sh_d = '0;
            c_d      = 1'b0;
            cnt_d    = '0;
        end else if (state_q == RUN) begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            sum_sh_d = {s_bit, sum_sh_q[WIDTH-1:1]};
            c_d      = c_next;
            cnt_d    = cnt_q + CW'(1);
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    // Carry into the MSB is c_q on the last bit; carry out is c_next.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == IDLE && in_valid) begin
            ovf_d = 1'b0;
        end else if (state_q == RUN && last_bit) begin
            ovf_d = c_q ^ c_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign overflow = ovf_q;
`endif

    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
        sum       = sum_sh_q;
        carry     = c_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
// Overflow checks are compiled in when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
`ifdef SERIAL_ADDER_OVF_EN
    logic             overflow;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .overflow  (overflow),
`endif
        .carry     (carry)
    );

    always #5 clk = ~clk;

    // Drives one input handshake; returns just after the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL start_ready in_ready=%0b required=1", in_ready);
        end
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
    endtask

    // Counts cycles after the handshake until out_valid is seen (0 = timeout).
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs in_ready=%0b out_valid=%0b required=0/0",
                     in_ready, out_valid);
        end
        checks++;
        if (sum !== 8'h00 || carry !== 1'b0) begin
            failures++;
            $display("FAIL reset_result sum=%h carry=%0b required=00/0", sum, carry);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf overflow=%0b required=0", overflow);
        end
`endif
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release in_ready=%0b required=1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [WIDTH-1:0] va [3];
        logic [WIDTH-1:0] vb [3];
        logic [WIDTH-1:0] es [3];
        logic             ec [3];
        logic             eo [3];
        int cyc;
        va[0] = 8'h00; vb[0] = 8'h00; es[0] = 8'h00; ec[0] = 1'b0; eo[0] = 1'b0;
        va[1] = 8'hFF; vb[1] = 8'h01; es[1] = 8'h00; ec[1] = 1'b1; eo[1] = 1'b0;
        va[2] = 8'h7F; vb[2] = 8'h01; es[2] = 8'h80; ec[2] = 1'b0; eo[2] = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_op(va[i], vb[i]);
            wait_done(cyc);
            checks++;
            if (cyc != WIDTH + 1) begin
                failures++;
                $display("FAIL basic_latency[%0d] cycles=%0d required=%0d", i, cyc, WIDTH + 1);
            end
            checks++;
            if (sum !== es[i] || carry !== ec[i]) begin
                failures++;
                $display("FAIL basic_sum[%0d] sum=%h carry=%0b required=%h/%0b",
                         i, sum, carry, es[i], ec[i]);
            end
`ifdef SERIAL_ADDER_OVF_EN
            checks++;
            if (overflow !== eo[i]) begin
                failures++;
                $display("FAIL basic_ovf[%0d] overflow=%0b required=%0b", i, overflow, eo[i]);
            end
`endif
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL basic_idle[%0d] in_ready=%0b out_valid=%0b required=1/0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        int bad;
        out_ready = 1'b0;
        start_op(8'h3C, 8'hA5);
        wait_done(cyc);
        checks++;
        if (cyc != WIDTH + 1) begin
            failures++;
            $display("FAIL bp_latency cycles=%0d required=%0d", cyc, WIDTH + 1);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || sum !== 8'hE1 || carry !== 1'b0 || in_ready !== 1'b0)
                bad++;
`ifdef SERIAL_ADDER_OVF_EN
            if (overflow !== 1'b0) bad++;
`endif
            in_valid = (i % 2 == 0);
            a = 8'h11;
            b = 8'h22;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold bad_cycles=%0d required=0 (sum=%h carry=%0b)", bad, sum, carry);
        end
        checks++;
        if (out_valid !== 1'b1 || sum !== 8'hE1) begin
            failures++;
            $display("FAIL bp_still_done out_valid=%0b sum=%h required=1/e1", out_valid, sum);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release in_ready=%0b out_valid=%0b required=1/0",
                     in_ready, out_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_no_ghost in_ready=%0b required=1", in_ready);
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        int seen;
        out_ready = 1'b1;
        start_op(8'hAA, 8'h55);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_run_ready in_ready=%0b required=0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_run_release in_ready=%0b required=1", in_ready);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_run_no_valid out_valid_cycles=%0d required=0", seen);
        end
        start_op(8'h12, 8'h34);
        wait_done(cyc);
        checks++;
        if (cyc == 0 || sum !== 8'h46 || carry !== 1'b0) begin
            failures++;
            $display("FAIL rst_run_next cycles=%0d sum=%h carry=%0b required=46/0",
                     cyc, sum, carry);
        end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH:0]   exp_q [$];
        logic             eov_q [$];
        logic [WIDTH-1:0] av, bv;
        logic [WIDTH:0]   full;
        logic             ov;
        int issued, got, cyc, last_hs;
        issued = 0;
        got = 0;
        last_hs = 0;
        out_ready = 1'b1;
        @(negedge clk);
        for (cyc = 0; cyc < 20 * (WIDTH + 2) + 60 && got < 20; cyc++) begin
            if (out_valid) begin
                full = exp_q.pop_front();
                ov = eov_q.pop_front();
                checks++;
                if ({carry, sum} !== full) begin
                    failures++;
                    $display("FAIL b2b_sum[%0d] got=%h required=%h", got, {carry, sum}, full);
                end
`ifdef SERIAL_ADDER_OVF_EN
                checks++;
                if (overflow !== ov) begin
                    failures++;
                    $display("FAIL b2b_ovf[%0d] overflow=%0b required=%0b", got, overflow, ov);
                end
`endif
                got++;
            end
            if (in_ready && issued < 20) begin
                av = WIDTH'($urandom);
                bv = WIDTH'($urandom);
                full = {1'b0, av} + {1'b0, bv};
                exp_q.push_back(full);
                eov_q.push_back((av[WIDTH-1] == bv[WIDTH-1]) && (full[WIDTH-1] != av[WIDTH-1]));
                if (issued > 0) begin
                    checks++;
                    if (cyc - last_hs != WIDTH + 2) begin
                        failures++;
                        $display("FAIL b2b_spacing[%0d] cycles=%0d required=%0d",
                                 issued, cyc - last_hs, WIDTH + 2);
                    end
                end
                last_hs = cyc;
                issued++;
                in_valid = 1'b1;
                a = av;
                b = bv;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (got != 20) begin
            failures++;
            $display("FAIL b2b_count results=%0d required=20", got);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_reset_mid_run;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
